// File: rtl/isi_defs_pkg.sv
// Shared definitions for the ISI sampling path: state encoding and the default
// interval width, which the gain stage also uses.
package isi_defs;

    localparam int BIT_ISI = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } isi_state_t;

endpackage

// File: rtl/isi_pending_slot.sv
// One-entry holding register for the next interval. Load wins over take, so a
// simultaneous take+load hands the old value out and captures the new one.
module isi_pending_slot
    import isi_defs::*;
#(
    parameter int width = BIT_ISI
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             take,
    input  logic [width-1:0] din,
    output logic             full,
    output logic [width-1:0] dout
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/isi_spike_timer.sv
// Turns each scaled inter-spike interval into a one-cycle spike after that many
// timebase ticks, with one interval of look-ahead so chained intervals have no gap.
module isi_spike_timer
    import isi_defs::*;
#(
    parameter int bit_isi = BIT_ISI
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [bit_isi-1:0] isi_z,
    input  logic               valid,
    input  logic               tick,
    output logic               spike,
    output logic               busy,
    output logic               pending_full,
    output logic               drop,
    output logic [bit_isi-1:0] cnt
);

    isi_state_t         state;
    isi_state_t         state_next;
    logic [bit_isi-1:0] cnt_next;
    logic               spike_next;
    logic               drop_next;
    logic               pend_load;
    logic               pend_take;
    logic [bit_isi-1:0] pend_data;
    logic               valid_nz;
    logic               zero_valid;
    logic               expiry;

    assign valid_nz     = valid && (isi_z != '0);
    assign zero_valid   = valid && (isi_z == '0);
    assign expiry       = (state == ST_RUN) && tick && (cnt == bit_isi'(1));
    assign busy         = (state == ST_RUN);

    isi_pending_slot #(
        .width(bit_isi)
    ) u_pending (
        .clk  (clk),
        .clr  (clr),
        .load (pend_load),
        .take (pend_take),
        .din  (isi_z),
        .full (pending_full),
        .dout (pend_data)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
            spike <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            spike <= spike_next;
            drop  <= drop_next;
        end
    end

    // At expiry the successor is chosen pending-first, so a coincident valid
    // either refills the slot or loads straight into the counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        spike_next = 1'b0;
        drop_next  = zero_valid;
        pend_load  = 1'b0;
        pend_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_nz) begin
                    cnt_next   = isi_z;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (expiry) begin
                    spike_next = 1'b1;
                    if (pending_full) begin
                        cnt_next  = pend_data;
                        pend_take = 1'b1;
                        pend_load = valid_nz;
                    end else if (valid_nz) begin
                        cnt_next = isi_z;
                    end else begin
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (tick) begin
                        cnt_next = cnt - 1'b1;
                    end
                    if (valid_nz) begin
                        if (pending_full) begin
                            drop_next = 1'b1;
                        end else begin
                            pend_load = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule
